circle_sort: RTL



---
 rtl/circle_sort_pkg.sv | 23 ++
 rtl/circle_sort_if.sv | 22 ++
 rtl/circle_sort_oets.sv | 30 +++
 rtl/circle_sort.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/circle_sort_pkg.sv
// Shared widths, frame/sort constants and FSM state type for the circle_sort responder.
package circle_sort_pkg;

    localparam int unsigned DW_IN       = 5;
    localparam int unsigned DW_OUT      = DW_IN + 1;
    localparam int unsigned N           = 8;
    localparam int unsigned BEATS       = 16;
    localparam int unsigned SORT_PHASES = 8;

    typedef logic [DW_IN-1:0]  din_t;
    typedef logic [DW_OUT-1:0] sum_t;
    typedef din_t [N-1:0]      ring_t;
    typedef sum_t [N-1:0]      sum_vec_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSum,
        StSort,
        StOut
    } state_e;

endpackage

// File: rtl/circle_sort_if.sv
// Frame-in / burst-out stream bundle; master is the stimulus side, slave is circle_sort.
interface circle_sort_if;
    import circle_sort_pkg::*;

    logic       in_valid;
    logic [2:0] circle1;
    logic [2:0] circle2;
    din_t       in;
    sum_t       out;
    logic       out_valid;

    modport master (
        output in_valid, circle1, circle2, in,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, circle1, circle2, in,
        output out, out_valid
    );

endinterface

// File: rtl/circle_sort_oets.sv
// One combinational odd-even transposition phase over the 8-entry sum vector.
// CIRCLE_SORT_DESC_EN flips the compare-swap so the result is largest-first.
module circle_sort_oets
    import circle_sort_pkg::*;
(
    input  sum_vec_t din,
    input  logic     odd,
    output sum_vec_t dout
);

    function automatic logic out_of_order(input sum_t a, input sum_t b);
`ifdef CIRCLE_SORT_DESC_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // Pairs (j, j+1) take part when j's parity matches the phase; equal values stay put.
    always_comb begin
        dout = din;
        for (int j = 0; j < int'(N) - 1; j++) begin
            if (((j % 2) == 1) == odd && out_of_order(din[j], din[j+1])) begin
                dout[j]   = din[j+1];
                dout[j+1] = din[j];
            end
        end
    end

endmodule

// File: rtl/circle_sort.sv
// circle_sort top: loads a 16-beat frame into two rotated rings, sums, sorts, bursts 8 sums.
// Sort direction is set by CIRCLE_SORT_DESC_EN inside circle_sort_oets.
module circle_sort
    import circle_sort_pkg::*;
(
    input logic          clk,
    input logic          rst,
    circle_sort_if.slave bus
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;   // beat index in LOAD, phase in SORT, beat index in OUT
    logic [2:0] c1_q, c2_q;
    ring_t      num1_q, num2_q;
    sum_vec_t   s_q, s_sorted;
    sum_t       out_q;
    logic       out_valid_q;
    logic [2:0] idx1, idx2;

    assign idx1 = cnt_q[2:0] + c1_q;
    assign idx2 = cnt_q[2:0] + c2_q;

    circle_sort_oets u_oets (
        .din  (s_sorted_src()),
        .odd  (cnt_q[0]),
        .dout (s_sorted)
    );

    function automatic sum_vec_t s_sorted_src();
        return s_q;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StLoad;
                    cnt_d   = 4'd1;
                end
            end
            StLoad: begin
                if (!bus.in_valid) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == 4'(BEATS - 1)) begin
                    state_d = StSum;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSum: begin
                state_d = StSort;
                cnt_d   = '0;
            end
            StSort: begin
                if (cnt_q == 4'(SORT_PHASES - 1)) begin
                    state_d = StOut;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StOut: begin
                if (cnt_q == 4'(N - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c1_q        <= '0;
            c2_q        <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            s_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        c1_q                 <= bus.circle1;
                        c2_q                 <= bus.circle2;
                        num1_q[bus.circle1]  <= bus.in;
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        if (!cnt_q[3]) begin
                            num1_q[idx1] <= bus.in;
                        end else begin
                            num2_q[idx2] <= bus.in;
                        end
                    end
                end
                StSum: begin
                    for (int k = 0; k < int'(N); k++) begin
                        s_q[k] <= sum_t'(num1_q[k]) + sum_t'(num2_q[k]);
                    end
                end
                StSort: begin
                    s_q <= s_sorted;
                end
                StOut: begin
                    out_q       <= s_q[0];
                    out_valid_q <= 1'b1;
                    s_q         <= s_q >> DW_OUT;
                end
                default: ;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule
